// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word reads to
// instruction memory and queues returned words (with their PCs) toward decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic        misaligned_fault
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [31:0]   r_pc;
    logic [31:0]   w_pc_next;
    logic [31:0]   r_req_pc;
    logic          w_latch_req;

    logic [31:0]   r_fifo_instr [FIFO_DEPTH];
    logic [31:0]   r_fifo_pc    [FIFO_DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_hold_instr;
    logic [31:0]   r_hold_pc;
    logic          r_fault;

    logic          w_empty;
    logic          w_full;
    logic          w_issue;
    logic          w_fire;
    logic          w_push;
    logic          w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    // Request only when the returning word is guaranteed a FIFO slot.
    assign w_issue = (r_state == FETCH) && !w_full && !rst;
    assign w_fire  = w_issue && imem_gnt;
    assign w_push  = (r_state == WAIT) && imem_rvalid && !redirect_valid;
    assign w_pop   = !w_empty && instr_ready && !redirect_valid;

    assign imem_req         = w_issue;
    assign imem_addr        = r_pc;
    assign instr_valid      = !w_empty;
    assign instr            = w_empty ? r_hold_instr : r_fifo_instr[r_rd_ptr];
    assign instr_pc         = w_empty ? r_hold_pc    : r_fifo_pc[r_rd_ptr];
    assign misaligned_fault = r_fault;

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_latch_req  = 1'b0;
        case (r_state)
            FETCH: begin
                if (w_fire) begin
                    if (redirect_valid) begin
                        w_state_next = DISCARD;
                    end else begin
                        w_state_next = WAIT;
                        w_pc_next    = r_pc + 32'd4;
                        w_latch_req  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    w_state_next = FETCH;
                end else if (redirect_valid) begin
                    w_state_next = DISCARD;
                end
            end
            DISCARD: begin
                if (imem_rvalid) begin
                    w_state_next = FETCH;
                end
            end
            default: w_state_next = FETCH;
        endcase
        // A redirect overrides any sequential increment, including a same-cycle grant.
        if (redirect_valid) begin
            w_pc_next = {redirect_pc[31:2], 2'b00};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= FETCH;
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
            r_fault  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_fault <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (w_latch_req) begin
                r_req_pc <= r_pc;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_fifo_instr[gi] <= '0;
                    r_fifo_pc[gi]    <= '0;
                end else if (w_push && (r_wr_ptr == AW'(gi))) begin
                    r_fifo_instr[gi] <= imem_rdata;
                    r_fifo_pc[gi]    <= r_req_pc;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_hold_instr <= '0;
            r_hold_pc    <= '0;
        end else begin
            // Remember the head so the outputs stay stable once the FIFO drains.
            if (!w_empty) begin
                r_hold_instr <= r_fifo_instr[r_rd_ptr];
                r_hold_pc    <= r_fifo_pc[r_rd_ptr];
            end
            if (redirect_valid) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                r_wr_ptr <= r_wr_ptr + AW'(w_push);
                r_rd_ptr <= r_rd_ptr + AW'(w_pop);
                r_count  <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised and directed bench for fetch_unit: a memory model serves grants,
// a scoreboard of expected program-order fetches is checked at every decode pop.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        misaligned_fault;

    fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .misaligned_fault(misaligned_fault)
    );

    int   checks = 0;
    int   errors = 0;
    int   pops = 0;
    int   cyc = 0;
    int   first_grant = -1;
    int   first_valid = -1;
    int   gnt_mode = 1;      // 0: never, 1: always, 2: random
    int   lat_mode = 1;      // 0: random 1..3, else fixed latency
    int   mem_pend = 0;
    logic chk_outstanding = 1'b1;
    exp_t exp_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0000_0013 + (a >> 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Expected decode stream after (re)start: consecutive words from the target.
    task automatic reload(input logic [31:0] start);
        logic [31:0] p;
        p = {start[31:2], 2'b00};
        exp_q.delete();
        for (int i = 0; i < 512; i++) begin
            exp_q.push_back('{pc: p, word: mem_word(p)});
            p = p + 32'd4;
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: one outstanding read, response after the chosen latency.
    initial begin
        logic        fire;
        logic [31:0] addr;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        addr        = 32'h0;
        forever begin
            @(negedge clk); #4;
            fire = imem_req && imem_gnt && !rst;
            if (fire) addr = imem_addr;
            @(posedge clk); #1;
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (fire) mem_pend = (lat_mode == 0) ? int'($urandom_range(1, 3)) : lat_mode;
            if (mem_pend == 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(addr);
                mem_pend    = 0;
            end else if (mem_pend > 1) begin
                mem_pend--;
            end
            imem_gnt = (gnt_mode == 0) ? 1'b0 : (gnt_mode == 1) ? 1'b1 : 1'($urandom % 2);
        end
    end

    // Monitor: samples late in each cycle, pops the scoreboard on every accepted instruction.
    initial begin
        logic prev_mis;
        logic prev_redir;
        exp_t e;
        prev_mis   = 1'b0;
        prev_redir = 1'b0;
        forever begin
            @(negedge clk); #3;
            if (rst) begin
                prev_mis   = 1'b0;
                prev_redir = 1'b0;
            end else begin
                chk("fault_pulse", {31'b0, misaligned_fault}, {31'b0, prev_mis});
                if (prev_redir) chk("flush_after_redirect", {31'b0, instr_valid}, 32'd0);
                if (imem_req && chk_outstanding)
                    chk("single_outstanding", {31'b0, (mem_pend != 0) || imem_rvalid}, 32'd0);
                if (imem_req && imem_gnt && first_grant < 0) first_grant = cyc;
                if (instr_valid && first_valid < 0) first_valid = cyc;
                if (instr_valid && instr_ready && !redirect_valid) begin
                    pops++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_instr actual_pc=%h required=none", instr_pc);
                    end else begin
                        e = exp_q.pop_front();
                        $display("pop pc=%h instr=%h", instr_pc, instr);
                        chk("instr_pc", instr_pc, e.pc);
                        chk("instr", instr, e.word);
                    end
                end
                prev_mis   = redirect_valid && (redirect_pc[1:0] != 2'b00);
                prev_redir = redirect_valid;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic wait_pops(input int n, input int budget, input string name);
        int start;
        start = pops;
        for (int i = 0; i < budget && pops < start + n; i++) tick();
        chk(name, {31'b0, pops >= start + n}, 32'd1);
    endtask

    task automatic rst_pulse();
        chk_outstanding = 1'b0;
        rst = 1'b1;
        repeat (4) tick();
        chk_outstanding = 1'b1;
        rst = 1'b0;
        reload(RST_PC);
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        reload(target);
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_outstanding(input string name);
        int i;
        for (i = 0; i < 40 && mem_pend == 0; i++) tick();
        chk(name, {31'b0, mem_pend != 0}, 32'd1);
    endtask

    initial begin
        int   p0;
        logic found;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b1;

        // Reset values and straight-line fetch at 1-cycle memory latency.
        repeat (3) tick();
        chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_fault", {31'b0, misaligned_fault}, 32'd0);
        rst = 1'b0;
        reload(RST_PC);
        repeat (12) tick();
        chk("first_valid_latency", 32'(first_valid - first_grant), 32'd2);
        p0 = pops;
        repeat (20) tick();
        chk("throughput_20cyc", 32'(pops - p0), 32'd10);

        // Decode stalled: two entries buffered, no further requests.
        instr_ready = 1'b0;
        rst_pulse();
        repeat (10) tick();
        chk("full_valid", {31'b0, instr_valid}, 32'd1);
        chk("full_head_pc", instr_pc, 32'h0);
        chk("full_head_instr", instr, mem_word(32'h0));
        for (int i = 0; i < 3; i++) begin
            chk("full_no_req", {31'b0, imem_req}, 32'd0);
            tick();
        end
        instr_ready = 1'b1;
        wait_pops(4, 40, "resume_after_stall");

        // Redirect while waiting on a slow memory.
        lat_mode = 3;
        wait_outstanding("wait_state_reached");
        redirect(32'h0000_0100);
        wait_pops(2, 60, "redirect_in_wait");

        // Redirect in the same cycle as the grant for PC 8.
        lat_mode = 1;
        rst_pulse();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk); #1;
            if (imem_req && imem_gnt && imem_addr == 32'h8) begin
                found          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = 32'h0000_0200;
                reload(32'h0000_0200);
                @(posedge clk); #2;
                redirect_valid = 1'b0;
            end
        end
        chk("grant_pc8_seen", {31'b0, found}, 32'd1);
        wait_pops(2, 40, "redirect_on_grant");

        // Misaligned redirect target.
        redirect(32'h0000_0102);
        chk("misaligned_pulse_on", {31'b0, misaligned_fault}, 32'd1);
        tick();
        chk("misaligned_pulse_off", {31'b0, misaligned_fault}, 32'd0);
        wait_pops(2, 40, "misaligned_resume");

        // Reset during WAIT followed by a late response.
        lat_mode = 3;
        wait_outstanding("wait_before_rst");
        chk_outstanding = 1'b0;
        gnt_mode = 0;
        rst = 1'b1;
        #1;
        chk("midrst_imem_req", {31'b0, imem_req}, 32'd0);
        chk("midrst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("midrst_instr", instr, 32'd0);
        chk("midrst_instr_pc", instr_pc, 32'd0);
        chk("midrst_fault", {31'b0, misaligned_fault}, 32'd0);
        tick();
        rst = 1'b0;
        reload(RST_PC);
        repeat (4) tick();
        chk("late_rvalid_ignored", {31'b0, instr_valid}, 32'd0);
        chk("refetch_addr", imem_addr, RST_PC);
        gnt_mode = 1;
        chk_outstanding = 1'b1;
        wait_pops(2, 40, "restart_after_rst");

        // Random traffic: grants, latencies, stalls and redirects.
        gnt_mode = 2;
        lat_mode = 0;
        p0 = pops;
        for (int i = 0; i < 3000; i++) begin
            instr_ready = ($urandom % 4) != 0;
            if ($urandom % 16 == 0) begin
                case ($urandom % 4)
                    0:       redirect($urandom & 32'h0000_0FFC);
                    1:       redirect(32'hFFFF_FFE0 | ($urandom & 32'h1C));
                    2:       redirect($urandom);
                    default: redirect(($urandom & 32'h0000_0FFC) | 32'h1);
                endcase
            end else begin
                tick();
            end
        end
        chk("random_progress", {31'b0, (pops - p0) > 200}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control unit.
- Holds the PC and issues word reads to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words with their PCs in a small FIFO and presents them to decode over valid/ready.
- Accepts redirects (branch, jump, trap entry, mret) that flush all in-flight and buffered fetches.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, number of instruction entries buffered toward decode (power of two, >= 2).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- imem_req  output  1  fetch request valid
- imem_addr  output  32  word-aligned fetch address
- imem_gnt  input  1  memory accepts request this cycle
- imem_rvalid  input  1  read data valid
- imem_rdata  input  32  read data
- redirect_valid  input  1  redirect the PC this cycle
- redirect_pc  input  32  redirect target
- instr_valid  output  1  instr/instr_pc valid toward decode
- instr  output  32  instruction word
- instr_pc  output  32  PC of instr
- instr_ready  input  1  decode consumes the head entry
- misaligned_fault  output  1  one-cycle pulse: redirect_pc[1:0] != 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: pc=RESET_PC, state=FETCH, FIFO empty, imem_req=0, instr_valid=0, instr=0, instr_pc=0, misaligned_fault=0. imem_req is held 0 while rst is high.
- FSM has three states: FETCH, WAIT, DISCARD. At most one request is outstanding.
- FETCH:
  - imem_req=1 iff FIFO count < FIFO_DEPTH.
  - imem_addr=pc.
  - On imem_req & imem_gnt: latch req_pc=pc, pc<=pc+4 (32-bit wrap, 32'hFFFF_FFFC+4=0), go to WAIT.
- WAIT:
  - imem_req=0.
  - On imem_rvalid: push {imem_rdata, req_pc}, go to FETCH.
  - Peak throughput is one instruction per 2 cycles.
- DISCARD:
  - imem_req=0.
  - On imem_rvalid: drop the data, go to FETCH.
- FIFO:
  - Head entry drives instr/instr_pc directly from registers.
  - instr_valid = !empty.
  - Pop on instr_valid & instr_ready.
  - Push and pop in the same cycle keep the count unchanged.
  - Push is never attempted when full; the issue check guarantees space.
  - When empty, instr and instr_pc hold their last values; instr_valid=0.
- Latency: gnt at cycle N, rvalid at N+1 → instr_valid=1 at N+2.
- Redirect (redirect_valid=1), highest priority, takes effect at the next edge:
  - FIFO is flushed; a same-cycle pop is ignored.
  - pc <= {redirect_pc[31:2],2'b00}.
  - misaligned_fault=1 for exactly the next cycle if redirect_pc[1:0]!=0.
  - FETCH with imem_req&imem_gnt in the same cycle: go to DISCARD; pc is not incremented.
  - FETCH without grant: stay in FETCH.
  - WAIT without imem_rvalid: go to DISCARD.
  - WAIT with imem_rvalid in the same cycle: drop the data, go to FETCH.
  - DISCARD with imem_rvalid: go to FETCH. Without imem_rvalid: stay in DISCARD.
  - No instruction fetched before the redirect is ever presented after it.
- Back-to-back redirects: the last one wins; the state rules apply each cycle.
- rst asserted mid-operation: immediate return to reset values; any late imem_rvalid is ignored because the state is FETCH.
- imem_rvalid in FETCH is ignored (protocol violation, no state change).

Test Plan:
- Release reset, memory with 1-cycle latency holding word i = 32'h0000_0013+i, instr_ready=1 → instr_pc sequence 0,4,8,... with matching words; first instr_valid 2 cycles after first grant; one instruction per 2 cycles.
- Hold instr_ready=0 after reset → exactly 2 entries buffered (PC 0,4). imem_req stays 0 while full. Raising instr_ready resumes fetch at PC 8 with no gap or duplicate.
- Redirect to 32'h0000_0100 while in WAIT with a 3-cycle memory latency → stale response dropped, FIFO flushed; next instr_pc=32'h100, then 32'h104.
- Redirect to 32'h0000_0200 in the same cycle as imem_gnt for PC 8 → PC 8 data never appears; pc goes to 32'h200, not 32'h204.
- redirect_pc=32'h0000_0102 → misaligned_fault pulses for one cycle; fetch resumes at 32'h100.
- Assert rst while in WAIT, release, then deliver a late imem_rvalid → it is ignored; fetch restarts at RESET_PC; all outputs read 0 during reset.
